// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard unit.
// Optional feature macro: MULDIV_STALL_EN (multi-cycle mul/div stall in EX).
package hazard_pkg;

    localparam int         RA_W       = 5;
    localparam logic [1:0] LOAD_SRC   = 2'b01;
    localparam int         MD_LATENCY = 4;

    // EX operand source select: regfile, WB result, or MEM ALU result.
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX operand: MEM result beats WB result, x0 never forwards.
module hazard_fwd_sel #(
    parameter int RA_W = hazard_pkg::RA_W
) (
    input  logic [RA_W-1:0]     ad_e,
    input  logic                regWrtm,
    input  logic [RA_W-1:0]     rdm,
    input  logic                regWrtw,
    input  logic [RA_W-1:0]     rdw,
    output hazard_pkg::fwd_sel_e sel
);
    import hazard_pkg::*;

    // Pick the youngest in-flight producer of this operand.
    always_comb begin
        sel = FWD_RF;
        if (regWrtm && (rdm != '0) && (rdm == ad_e)) begin
            sel = FWD_MEM;
        end else if (regWrtw && (rdw != '0) && (rdw == ad_e)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Stall / flush / forward control for the in-order 5-stage pipeline.
// Keeps shadow tags of the EX, MEM and WB stages captured from decode.
// Optional feature macro: MULDIV_STALL_EN adds mdOpd, stalle, flushm and a
// multi-cycle mul/div hold of the EX stage.
module hazard_unit #(
    parameter int         RA_W       = hazard_pkg::RA_W,
`ifdef MULDIV_STALL_EN
    parameter int         MD_LATENCY = hazard_pkg::MD_LATENCY,
`endif
    parameter logic [1:0] LOAD_SRC   = hazard_pkg::LOAD_SRC
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [RA_W-1:0] ad1d,
    input  logic [RA_W-1:0] ad2d,
    input  logic [RA_W-1:0] rdd,
    input  logic            regWrtd,
    input  logic [1:0]      resltSrcd,
    input  logic            jmpd,
    input  logic            branchd,
    input  logic            zeroe,
`ifdef MULDIV_STALL_EN
    input  logic            mdOpd,
    output logic            stalle,
    output logic            flushm,
`endif
    output logic            pcSrce,
    output logic [1:0]      fwdAe,
    output logic [1:0]      fwdBe,
    output logic            stallf,
    output logic            stalld,
    output logic            flushd,
    output logic            flushe
);
    import hazard_pkg::*;

    // EX shadow
    logic [RA_W-1:0] ad1e_q, ad1e_d;
    logic [RA_W-1:0] ad2e_q, ad2e_d;
    logic [RA_W-1:0] rde_q, rde_d;
    logic            regWrte_q, regWrte_d;
    logic [1:0]      resltSrce_q, resltSrce_d;
    logic            jmpe_q, jmpe_d;
    logic            branche_q, branche_d;

    // MEM and WB shadows
    logic [RA_W-1:0] rdm_q, rdm_d;
    logic            regWrtm_q, regWrtm_d;
    logic [RA_W-1:0] rdw_q, rdw_d;
    logic            regWrtw_q, regWrtw_d;

    logic            lw_stall;
    logic            pc_redirect;
    logic            md_stall;
    fwd_sel_e        fwd_a;
    fwd_sel_e        fwd_b;

`ifdef MULDIV_STALL_EN
    localparam int CNT_W = $clog2(MD_LATENCY) + 1;

    logic             mdOpe_q, mdOpe_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             md_start;

    // The mul/div occupies EX for MD_LATENCY cycles; the final count slot
    // releases the hold so the op leaves EX as the counter drains to zero.
    always_comb begin
        md_start = mdOpe_q && (md_cnt_q == '0);
        md_stall = md_start || (md_cnt_q > CNT_W'(1));
        md_cnt_d = md_cnt_q;
        if (md_start) begin
            md_cnt_d = CNT_W'(MD_LATENCY - 1);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    // Shadow of the mul/div flag: holds while stalled, bubbles on flush.
    always_comb begin
        mdOpe_d = mdOpd;
        if (md_stall) begin
            mdOpe_d = mdOpe_q;
        end else if (flushe) begin
            mdOpe_d = 1'b0;
        end
    end

    // Counter and mul/div flag state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= '0;
            mdOpe_q  <= 1'b0;
        end else begin
            md_cnt_q <= md_cnt_d;
            mdOpe_q  <= mdOpe_d;
        end
    end

    assign stalle = md_stall;
    assign flushm = md_stall;
`else
    assign md_stall = 1'b0;
`endif

    // Load-use hazard and taken-redirect detection from the EX shadow.
    always_comb begin
        lw_stall = regWrte_q && (resltSrce_q == LOAD_SRC) && (rde_q != '0) &&
                   ((rde_q == ad1d) || (rde_q == ad2d));
        pc_redirect = (jmpe_q || (branche_q && zeroe)) && !md_stall;
    end

    assign pcSrce = pc_redirect;
    assign stallf = lw_stall || md_stall;
    assign stalld = lw_stall || md_stall;
    assign flushd = pc_redirect;
    assign flushe = lw_stall || pc_redirect;

    // Next EX shadow: decode tags, a bubble on flush, or a hold under mul/div.
    always_comb begin
        ad1e_d      = ad1d;
        ad2e_d      = ad2d;
        rde_d       = rdd;
        regWrte_d   = regWrtd;
        resltSrce_d = resltSrcd;
        jmpe_d      = jmpd;
        branche_d   = branchd;
        if (md_stall) begin
            ad1e_d      = ad1e_q;
            ad2e_d      = ad2e_q;
            rde_d       = rde_q;
            regWrte_d   = regWrte_q;
            resltSrce_d = resltSrce_q;
            jmpe_d      = jmpe_q;
            branche_d   = branche_q;
        end else if (flushe) begin
            ad1e_d      = '0;
            ad2e_d      = '0;
            rde_d       = '0;
            regWrte_d   = 1'b0;
            resltSrce_d = 2'b00;
            jmpe_d      = 1'b0;
            branche_d   = 1'b0;
        end
    end

    // MEM and WB advance every cycle; MEM takes a bubble behind a held mul/div.
    always_comb begin
        rdm_d     = rde_q;
        regWrtm_d = regWrte_q;
        if (md_stall) begin
            rdm_d     = '0;
            regWrtm_d = 1'b0;
        end
        rdw_d     = rdm_q;
        regWrtw_d = regWrtm_q;
    end

    // Shadow registers for all three downstream stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ad1e_q      <= '0;
            ad2e_q      <= '0;
            rde_q       <= '0;
            regWrte_q   <= 1'b0;
            resltSrce_q <= 2'b00;
            jmpe_q      <= 1'b0;
            branche_q   <= 1'b0;
            rdm_q       <= '0;
            regWrtm_q   <= 1'b0;
            rdw_q       <= '0;
            regWrtw_q   <= 1'b0;
        end else begin
            ad1e_q      <= ad1e_d;
            ad2e_q      <= ad2e_d;
            rde_q       <= rde_d;
            regWrte_q   <= regWrte_d;
            resltSrce_q <= resltSrce_d;
            jmpe_q      <= jmpe_d;
            branche_q   <= branche_d;
            rdm_q       <= rdm_d;
            regWrtm_q   <= regWrtm_d;
            rdw_q       <= rdw_d;
            regWrtw_q   <= regWrtw_d;
        end
    end

    hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .ad_e    (ad1e_q),
        .regWrtm (regWrtm_q),
        .rdm     (rdm_q),
        .regWrtw (regWrtw_q),
        .rdw     (rdw_q),
        .sel     (fwd_a)
    );

    hazard_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .ad_e    (ad2e_q),
        .regWrtm (regWrtm_q),
        .rdm     (rdm_q),
        .regWrtw (regWrtw_q),
        .rdw     (rdw_q),
        .sel     (fwd_b)
    );

    assign fwdAe = fwd_a;
    assign fwdBe = fwd_b;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit (default build, MULDIV_STALL_EN undefined).
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] ad1d, ad2d, rdd;
    logic       regWrtd;
    logic [1:0] resltSrcd;
    logic       jmpd, branchd, zeroe;
    logic       pcSrce;
    logic [1:0] fwdAe, fwdBe;
    logic       stallf, stalld, flushd, flushe;

    hazard_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ad1d      (ad1d),
        .ad2d      (ad2d),
        .rdd       (rdd),
        .regWrtd   (regWrtd),
        .resltSrcd (resltSrcd),
        .jmpd      (jmpd),
        .branchd   (branchd),
        .zeroe     (zeroe),
        .pcSrce    (pcSrce),
        .fwdAe     (fwdAe),
        .fwdBe     (fwdBe),
        .stallf    (stallf),
        .stalld    (stalld),
        .flushd    (flushd),
        .flushe    (flushe)
    );

    always #5 clk = ~clk;

    // One in-flight instruction as the rules see it.
    typedef struct packed {
        logic [4:0] ad1;
        logic [4:0] ad2;
        logic [4:0] rd;
        logic       wr;
        logic [1:0] src;
        logic       jmp;
        logic       br;
    } instr_t;

    // pipe[0] = EX, pipe[1] = MEM, pipe[2] = WB
    instr_t pipe [3];
    int     vectors     = 0;
    int     miscompares = 0;

    logic       exp_pc, exp_stall, exp_fld, exp_fle;
    logic [1:0] exp_fa, exp_fb;

    // Youngest older writer of a nonzero register wins; MEM is stage 1.
    function automatic logic [1:0] modelFwd(input logic [4:0] ad);
        for (int s = 1; s <= 2; s++) begin
            if (ad != 5'd0 && pipe[s].wr && pipe[s].rd == ad)
                return (s == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic clearModel();
        for (int s = 0; s < 3; s++) pipe[s] = '0;
    endtask

    task automatic computeModel();
        logic lw;
        if (!rst_n) begin
            exp_pc = 0; exp_fa = 0; exp_fb = 0;
            exp_stall = 0; exp_fld = 0; exp_fle = 0;
        end else begin
            lw = pipe[0].wr && pipe[0].src == 2'b01 && pipe[0].rd != 5'd0 &&
                 (pipe[0].rd == ad1d || pipe[0].rd == ad2d);
            exp_pc    = pipe[0].jmp || (pipe[0].br && zeroe);
            exp_fa    = modelFwd(pipe[0].ad1);
            exp_fb    = modelFwd(pipe[0].ad2);
            exp_stall = lw;
            exp_fld   = exp_pc;
            exp_fle   = lw || exp_pc;
        end
    endtask

    task automatic checkOne(input string name, input logic [1:0] act, input logic [1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        computeModel();
        checkOne("pcSrce", {1'b0, pcSrce}, {1'b0, exp_pc});
        checkOne("fwdAe",  fwdAe, exp_fa);
        checkOne("fwdBe",  fwdBe, exp_fb);
        checkOne("stallf", {1'b0, stallf}, {1'b0, exp_stall});
        checkOne("stalld", {1'b0, stalld}, {1'b0, exp_stall});
        checkOne("flushd", {1'b0, flushd}, {1'b0, exp_fld});
        checkOne("flushe", {1'b0, flushe}, {1'b0, exp_fle});
    endtask

    task automatic applyStimulus(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                                 input logic wr, input logic [1:0] src, input logic j,
                                 input logic b, input logic z);
        @(negedge clk);
        rst_n = 1'b1;
        ad1d = a1; ad2d = a2; rdd = rd; regWrtd = wr;
        resltSrcd = src; jmpd = j; branchd = b; zeroe = z;
        #1;
    endtask

    // Move the model one edge forward with the inputs held across that edge.
    task automatic advance();
        instr_t nxt;
        computeModel();
        nxt = exp_fle ? '0 : {ad1d, ad2d, rdd, regWrtd, resltSrcd, jmpd, branchd};
        @(posedge clk);
        if (rst_n) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = nxt;
        end
    endtask

    task automatic resetPulse();
        rst_n = 1'b0;
        #1;
        clearModel();
        checkOutput();
        checkOne("rst_stalld", {1'b0, stalld}, 2'b00);
        checkOne("rst_flushe", {1'b0, flushe}, 2'b00);
        checkOne("rst_pcSrce", {1'b0, pcSrce}, 2'b00);
        advance();
    endtask

    initial begin
        clearModel();
        rst_n = 1'b0;
        ad1d = 5'd3; ad2d = 5'd3; rdd = 5'd3; regWrtd = 1'b1;
        resltSrcd = 2'b01; jmpd = 1'b1; branchd = 1'b1; zeroe = 1'b1;
        #2;
        checkOutput();
        checkOne("reset_fwdAe", fwdAe, 2'b00);
        repeat (2) @(posedge clk);

        // add x5 ; sub x6, x5, x3 ; op x8, x0, x5
        applyStimulus(5'd1, 5'd2, 5'd5, 1, 2'b00, 0, 0, 0); checkOutput(); advance();
        applyStimulus(5'd5, 5'd3, 5'd6, 1, 2'b00, 0, 0, 0); checkOutput(); advance();
        applyStimulus(5'd0, 5'd5, 5'd8, 1, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_fwdA_mem", fwdAe, 2'b10);
        advance();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_fwdB_wb", fwdBe, 2'b01);
        advance();

        // lw x7 ; reader of x7 on rs2 (held in decode for the stall cycle)
        applyStimulus(5'd1, 5'd0, 5'd7, 1, 2'b01, 0, 0, 0); checkOutput(); advance();
        applyStimulus(5'd0, 5'd7, 5'd9, 1, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_lu_stallf", {1'b0, stallf}, 2'b01);
        checkOne("lit_lu_flushe", {1'b0, flushe}, 2'b01);
        checkOne("lit_lu_flushd", {1'b0, flushd}, 2'b00);
        advance();
        applyStimulus(5'd0, 5'd7, 5'd9, 1, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_lu_once", {1'b0, stalld}, 2'b00);
        advance();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_lu_fwdB", fwdBe, 2'b01);
        advance();

        // load into x0 followed by an x0 reader
        applyStimulus(5'd0, 5'd0, 5'd0, 1, 2'b01, 0, 0, 0); checkOutput(); advance();
        applyStimulus(5'd0, 5'd0, 5'd4, 1, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_x0_stall", {1'b0, stallf}, 2'b00);
        advance();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_x0_fwdA", fwdAe, 2'b00);
        checkOne("lit_x0_fwdB", fwdBe, 2'b00);
        advance();

        // branch in EX: taken then not taken
        applyStimulus(5'd1, 5'd2, 5'd0, 0, 2'b00, 0, 1, 0); checkOutput(); advance();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 1); checkOutput();
        checkOne("lit_br_pc",     {1'b0, pcSrce}, 2'b01);
        checkOne("lit_br_flushd", {1'b0, flushd}, 2'b01);
        zeroe = 1'b0;
        #1;
        checkOutput();
        checkOne("lit_br_nt", {1'b0, flushe}, 2'b00);
        advance();

        // jump redirects regardless of zeroe
        applyStimulus(5'd0, 5'd0, 5'd1, 1, 2'b00, 1, 0, 0); checkOutput(); advance();
        applyStimulus(5'd0, 5'd0, 5'd0, 0, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_jmp_pc", {1'b0, pcSrce}, 2'b01);
        advance();

        // load-use and jump together, then reset in the middle of the stall
        applyStimulus(5'd0, 5'd0, 5'd7, 1, 2'b01, 1, 0, 0); checkOutput(); advance();
        applyStimulus(5'd0, 5'd7, 5'd2, 1, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_both_stalld", {1'b0, stalld}, 2'b01);
        checkOne("lit_both_flushd", {1'b0, flushd}, 2'b01);
        checkOne("lit_both_flushe", {1'b0, flushe}, 2'b01);
        resetPulse();
        applyStimulus(5'd0, 5'd7, 5'd2, 1, 2'b00, 0, 0, 0); checkOutput();
        checkOne("lit_post_rst", {1'b0, stalld}, 2'b00);
        advance();

        // randomized traffic over a small register set to provoke hazards
        for (int i = 0; i < 600; i++) begin
            applyStimulus(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                          ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            checkOutput();
            if ($urandom_range(0, 99) == 0) resetPulse();
            else advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
